// File: rtl/brentkung_operand_stage.sv
// Handshake wrapper around an external combinational Brent-Kung adder:
// 2-entry operand FIFO feeding the adder bus, registered result, carry-event counter.
module brentkung_operand_stage #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [2*WIDTH-1:0] adder_in,
  input  logic [WIDTH:0]     adder_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH:0]     res_data,
  output logic [CNT_W-1:0]   carry_cnt,
  input  logic               cnt_clr
);

  // Adder bus convention: bit 2i carries A[i], bit 2i+1 carries B[i].
  function automatic logic [2*WIDTH-1:0] interleave(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      v[2*i]   = a[i];
      v[2*i+1] = b[i];
    end
    return v;
  endfunction

  logic [WIDTH-1:0] fifo_a_q [2];
  logic [WIDTH-1:0] fifo_b_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH:0]   res_data_q, res_data_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic             push, pop, carry_cap;

  assign in_ready  = (count_q < 2'd2);
  assign push      = in_valid & in_ready;
  assign pop       = (count_q != 2'd0) & (~res_valid_q | res_ready);
  assign carry_cap = pop & adder_out[WIDTH];

  assign adder_in  = (count_q != 2'd0) ? interleave(fifo_a_q[rd_ptr_q], fifo_b_q[rd_ptr_q])
                                       : '0;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign carry_cnt = carry_cnt_q;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    carry_cnt_d = carry_cnt_q;

    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      res_data_d  = adder_out;
      res_valid_d = 1'b1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    // A clear coinciding with a carry capture still records that capture.
    if (cnt_clr)
      carry_cnt_d = carry_cap ? CNT_W'(1) : '0;
    else if (carry_cap && (carry_cnt_q != {CNT_W{1'b1}}))
      carry_cnt_d = carry_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      carry_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  // Operand storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= in_a;
      fifo_b_q[wr_ptr_q] <= in_b;
    end
  end

endmodule

// File: tb/tb_brentkung_operand_stage.sv
// Bench for brentkung_operand_stage with a behavioural adder closing the loop.
module tb_brentkung_operand_stage;

  localparam int W = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, res_valid, res_ready, cnt_clr;
  logic [W-1:0]  in_a, in_b;
  logic [2*W-1:0] adder_in;
  logic [W:0]    adder_out, res_data;
  logic [7:0]    carry_cnt;

  logic          in_valid2, in_ready2, res_valid2;
  logic [W-1:0]  in_a2, in_b2;
  logic [2*W-1:0] adder_in2;
  logic [W:0]    adder_out2, res_data2;
  logic [1:0]    carry_cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [W:0] adder_model(input logic [2*W-1:0] bus);
    logic [W-1:0] a, b;
    for (int i = 0; i < W; i++) begin
      a[i] = bus[2*i];
      b[i] = bus[2*i+1];
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign adder_out  = adder_model(adder_in);
  assign adder_out2 = adder_model(adder_in2);

  brentkung_operand_stage #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .adder_in(adder_in), .adder_out(adder_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .carry_cnt(carry_cnt), .cnt_clr(cnt_clr));

  brentkung_operand_stage #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .adder_in(adder_in2), .adder_out(adder_out2),
    .res_valid(res_valid2), .res_ready(1'b1), .res_data(res_data2),
    .carry_cnt(carry_cnt2), .cnt_clr(1'b0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] ai;
    logic [W:0]     res;
    logic [7:0]     cnt;
  } vec_t;

  vec_t vecs [7];
  logic [W:0] sb [$];
  int got;

  initial begin
    vecs[0] = '{a: 12'hAAA, b: 12'h555, ai: 24'h666666, res: 13'h0FFF, cnt: 8'd0};
    vecs[1] = '{a: 12'h000, b: 12'h000, ai: 24'h000000, res: 13'h0000, cnt: 8'd0};
    vecs[2] = '{a: 12'h001, b: 12'h000, ai: 24'h000001, res: 13'h0001, cnt: 8'd0};
    vecs[3] = '{a: 12'h000, b: 12'h001, ai: 24'h000002, res: 13'h0001, cnt: 8'd0};
    vecs[4] = '{a: 12'hFFF, b: 12'h001, ai: 24'h555557, res: 13'h1000, cnt: 8'd1};
    vecs[5] = '{a: 12'hFFF, b: 12'hFFF, ai: 24'hFFFFFF, res: 13'h1FFE, cnt: 8'd2};
    vecs[6] = '{a: 12'h800, b: 12'h800, ai: 24'hC00000, res: 13'h1000, cnt: 8'd3};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1; cnt_clr = 1'b0;
    in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_carry_cnt", carry_cnt, 0);
    check("rst_adder_in", adder_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors, one pair at a time with a free output.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b;
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_adder_in", i), adder_in, vecs[i].ai);
      check($sformatf("v%0d_res_valid_early", i), res_valid, 0);
      tick();
      check($sformatf("v%0d_res_valid", i), res_valid, 1);
      check($sformatf("v%0d_res_data", i), res_data, vecs[i].res);
      check($sformatf("v%0d_carry_cnt", i), carry_cnt, vecs[i].cnt);
      tick();
      check($sformatf("v%0d_drain", i), res_valid, 0);
    end

    // Counter clear alone, then clear coincident with a carry capture.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_alone", carry_cnt, 0);
    in_valid = 1'b1; in_a = 12'hFFF; in_b = 12'h001;
    tick();
    in_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_with_carry", carry_cnt, 1);
    check("clr_with_carry_res", res_data, 13'h1000);
    tick();

    // Full backpressure: three pairs fit, the fourth waits.
    res_ready = 1'b0;
    in_valid = 1'b1; in_a = 12'd1; in_b = 12'd1;
    tick();
    in_a = 12'd2; in_b = 12'd2;
    check("bp_ready1", in_ready, 1);
    tick();
    check("bp_first_res", res_data, 13'h002);
    in_a = 12'd3; in_b = 12'd3;
    check("bp_ready2", in_ready, 1);
    tick();
    in_a = 12'd4; in_b = 12'd4;
    check("bp_full", in_ready, 0);
    tick();
    check("bp_still_full", in_ready, 0);
    check("bp_hold_valid", res_valid, 1);
    check("bp_hold_data", res_data, 13'h002);
    tick();
    check("bp_hold_data2", res_data, 13'h002);
    res_ready = 1'b1;
    tick();
    check("bp_out2", res_data, 13'h004);
    check("bp_ready_after", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_out3", res_data, 13'h006);
    tick();
    check("bp_out4", res_data, 13'h008);
    check("bp_out4_valid", res_valid, 1);
    tick();
    check("bp_empty", res_valid, 0);

    // Streaming with a scoreboard.
    got = 0;
    for (int i = 0; i < 104; i++) begin
      if (i < 100) begin
        in_valid = 1'b1;
        in_a = W'($urandom_range(0, 4095));
        in_b = W'($urandom_range(0, 4095));
        if (in_ready) sb.push_back({1'b0, in_a} + {1'b0, in_b});
        else check("stream_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (res_valid) begin
        if (sb.size() == 0) check("stream_unexpected", res_valid, 0);
        else check($sformatf("stream_%0d", got), res_data, sb.pop_front());
        got++;
      end
      if (i >= 1 && i <= 100) check($sformatf("stream_rate_%0d", i), res_valid, 1);
    end
    check("stream_count", got, 100);

    // Saturating counter with a 2-bit width.
    in_valid2 = 1'b1; in_a2 = 12'hFFF; in_b2 = 12'hFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 3) in_valid2 = 1'b0;
      if (k >= 1) begin
        check($sformatf("sat_cnt_%0d", k), carry_cnt2, (k == 4) ? 3 : k);
        check($sformatf("sat_res_%0d", k), res_data2, 13'h1FFE);
      end
    end

    // Asynchronous reset with work in flight.
    res_ready = 1'b0;
    in_valid = 1'b1; in_a = 12'hFFF; in_b = 12'hFFF;
    tick(); tick(); tick();
    in_valid = 1'b0;
    check("mid_full", in_ready, 0);
    check("mid_valid", res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_carry_cnt", carry_cnt, 0);
    check("mid_rst_adder_in", adder_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst_idle_%0d", i), res_valid, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/brentkung_operand_stage.md
Name: brentkung_operand_stage

Overview:
Registered handshake wrapper that sits directly upstream and downstream of the 12-bit combinational Brent-Kung adder. It accepts operand pairs on a valid/ready interface and buffers them in a 2-entry FIFO. The FIFO head drives the adder's 24-bit bit-interleaved input bus, and the stage captures the adder's 13-bit sum/carry result into an output register with valid/ready. It also keeps a saturating count of carry-out events.

Parameters:
WIDTH, 12, operand width; adder bus is 2*WIDTH in, WIDTH+1 out
CNT_W, 8, width of carry-out event counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  stage can accept a pair
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
adder_in  output  2*WIDTH  to adder INPUTS bus; bit 2i = A[i], bit 2i+1 = B[i]
adder_out  input  WIDTH+1  from adder OUTS bus; [WIDTH-1:0] sum, [WIDTH] carry-out
res_valid  output  1  result valid
res_ready  input  1  downstream accepts result
res_data  output  WIDTH+1  captured {carry, sum}
carry_cnt  output  CNT_W  saturating count of results with carry=1
cnt_clr  input  1  synchronous clear of carry_cnt

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: FIFO empty, in_ready=1, res_valid=0, res_data=0, carry_cnt=0, adder_in=0.
- Input acceptance:
  - Accept on a rising edge when in_valid & in_ready. The pair is written at the FIFO tail.
  - in_ready = (fifo_count < 2). It is derived from registered count only and has no combinational path from res_ready.
- Adder input:
  - adder_in is driven combinationally from the FIFO head entry only, never from in_a/in_b directly.
  - When the FIFO is empty, adder_in = 0.
- Pop/capture condition: fifo_count != 0 and (res_valid == 0 or res_ready == 1).
  - On that edge, res_data <= adder_out, res_valid <= 1, and the head is popped.
- Output drain: if res_valid & res_ready and nothing is popped, res_valid <= 0 and res_data holds its value.
- Simultaneous push and pop with count 2: push is not allowed, since in_ready=0.
  - With count 1: push and pop in the same cycle leaves count=1, and the new entry becomes head.
- Latency: pair accepted at edge E0 appears on res_data/res_valid after edge E1 (2 edges) when the output is free.
- Throughput: 1 pair/cycle sustained when res_ready=1.
- Capacity: 3 pairs total (2 FIFO + 1 output register) before in_ready drops under full backpressure.
- res_data stability: holds stable while res_valid=1 and res_ready=0 (AXI-style rule: no change until handshake).
- Carry counter:
  - Increments on each capture where adder_out[WIDTH]=1, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 with no coincident carry capture: carry_cnt <= 0.
  - cnt_clr=1 with a coincident carry capture: carry_cnt <= 1.
- Reset mid-operation: asserting rst_n=0 immediately empties the FIFO and clears res_valid and carry_cnt. In-flight pairs are discarded, and no result is produced for them after release.
- Widths: no arithmetic is performed in this block. The adder_out carry bit is passed unmodified into res_data[WIDTH].

Test Plan:
- Interleave check: in_a=0xAAA, in_b=0x555, res_ready=1 -> adder_in=0x666666 while at head; res_data=0x0FFF two edges after accept; carry_cnt stays 0.
- Carry case: in_a=0xFFF, in_b=0x001 -> res_data=0x1000, res_valid=1 after 2 edges, carry_cnt=1. Pulse cnt_clr alone -> carry_cnt=0. Pulse cnt_clr on the same edge as another carry capture -> carry_cnt=1.
- Backpressure: res_ready=0, push pairs (1,1),(2,2),(3,3),(4,4) back-to-back -> first three accepted, in_ready=0 on the 4th. res_data=0x002 is held stable. Raise res_ready -> results 0x002, 0x004, 0x006, 0x008 in order, no loss or duplication.
- Streaming: 100 random pairs with in_valid and res_ready held 1 -> one result per cycle after 2-cycle fill. Each res_data equals A+B (13-bit), checked against a scoreboard.
- Saturation: CNT_W=2, four captures of 0xFFF+0xFFF (result 0x1FFE) -> carry_cnt sequence 1,2,3,3.
- Reset mid-operation: two pairs buffered with res_valid=1, assert rst_n low asynchronously between edges -> in_ready=1, res_valid=0, carry_cnt=0 immediately. After release, no stale results appear.
